set_assoc_cache: RTL and testbench

Parametrised 2-way set-associative, write-through, no-write-allocate data cache between the MEM stage and the word-oriented memory controller. Serves read hits with zero stall. Refills a multi-word line on a read miss. Updates the cached copy on a write hit instead of invalidating it. Exposes a single `cpu_stall` that freezes the pipeline, plus a whole-cache flush.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_way_array.sv | 60 ++++++
 rtl/set_assoc_cache.sv | 194 +++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// ============================================================================
// Module   : cache_pkg
// Purpose  : Shared types and helpers for the 2-way set-associative data cache.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w - 2;
  endfunction

  // Fill empty ways first; only evict a live line when the set is full.
  function automatic logic select_victim(input logic valid0, input logic valid1, input logic lru);
    if (!valid0) return 1'b0;
    if (!valid1) return 1'b1;
    return lru;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_way_array.sv
// ============================================================================
// Module   : cache_way_array
// Purpose  : Valid/tag/data storage and tag compare for one cache way.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cache_way_array #(
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 1,
  parameter int TAG_W    = 9,
  parameter int DATA_W   = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [INDEX_W-1:0]                   index,
  input  logic [TAG_W-1:0]                     tag,
  input  logic [OFFSET_W-1:0]                  offset,
  output logic                                 hit,
  output logic                                 valid,
  output logic [DATA_W-1:0]                    rdata,
  input  logic                                 line_we,
  input  logic [(1<<OFFSET_W)-1:0][DATA_W-1:0] line_data,
  input  logic                                 word_we,
  input  logic [DATA_W-1:0]                    word_data
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  logic [SETS-1:0]                valid_q;
  logic [TAG_W-1:0]               tag_q  [SETS];
  logic [WORDS-1:0][DATA_W-1:0]   data_q [SETS];

  assign valid = valid_q[index];
  assign hit   = valid_q[index] && (tag_q[index] == tag);
  assign rdata = data_q[index][offset];

  // Flush outranks an install so a line filled during a flush stays invalid.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
    end else if (line_we) begin
      valid_q[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[index]  <= tag;
      data_q[index] <= line_data;
    end else if (word_we) begin
      data_q[index][offset] <= word_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/set_assoc_cache.sv
// ============================================================================
// Module   : set_assoc_cache
// Purpose  : 2-way write-through, no-write-allocate data cache with line refill.
// Revision : 1.0
// ============================================================================
`default_nettype none

module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int TAG_W  = tag_width(ADDR_W, INDEX_W, OFFSET_W);
  localparam int SETS   = 1 << INDEX_W;
  localparam int WORDS  = 1 << OFFSET_W;
  localparam int WADDR_W = ADDR_W - 2;
  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(WORDS - 1);

  state_t                       state_q, state_d;
  logic [WADDR_W-1:0]           req_word_q;
  logic [DATA_W-1:0]            req_wdata_q;
  logic [OFFSET_W-1:0]          beat_q;
  logic [WORDS-1:0][DATA_W-1:0] line_buf_q;
  logic [WORDS-1:0][DATA_W-1:0] line_data;
  logic [SETS-1:0]              lru_q;

  logic capture_wr, capture_rd, beat_inc;
  logic line_we0, line_we1, word_we0, word_we1;
  logic lru_we, lru_val;

  // Idle lookups follow the CPU; otherwise the latched request owns the arrays.
  logic [WADDR_W-1:0]  lk_word;
  logic [INDEX_W-1:0]  lk_index;
  logic [TAG_W-1:0]    lk_tag;
  logic [OFFSET_W-1:0] lk_offset;
  assign lk_word   = (state_q == IDLE) ? cpu_addr[ADDR_W-1:2] : req_word_q;
  assign lk_index  = lk_word[OFFSET_W +: INDEX_W];
  assign lk_tag    = lk_word[WADDR_W-1 -: TAG_W];
  assign lk_offset = lk_word[OFFSET_W-1:0];

  logic unused_byte_bits;
  assign unused_byte_bits = ^cpu_addr[1:0];

  logic              hit_w0, hit_w1, valid_w0, valid_w1, hit, victim;
  logic [DATA_W-1:0] rdata_w0, rdata_w1;
  assign hit    = hit_w0 | hit_w1;
  assign victim = select_victim(valid_w0, valid_w1, lru_q[lk_index]);

  cache_way_array #(.INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_way0 (
    .clk(clk), .rst(rst), .flush(flush),
    .index(lk_index), .tag(lk_tag), .offset(lk_offset),
    .hit(hit_w0), .valid(valid_w0), .rdata(rdata_w0),
    .line_we(line_we0), .line_data(line_data),
    .word_we(word_we0), .word_data(req_wdata_q)
  );

  cache_way_array #(.INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_way1 (
    .clk(clk), .rst(rst), .flush(flush),
    .index(lk_index), .tag(lk_tag), .offset(lk_offset),
    .hit(hit_w1), .valid(valid_w1), .rdata(rdata_w1),
    .line_we(line_we1), .line_data(line_data),
    .word_we(word_we1), .word_data(req_wdata_q)
  );

  // The final beat is installed straight from the bus, bypassing the buffer.
  always_comb begin
    line_data         = line_buf_q;
    line_data[beat_q] = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    capture_wr = 1'b0;
    capture_rd = 1'b0;
    beat_inc   = 1'b0;
    line_we0   = 1'b0;
    line_we1   = 1'b0;
    word_we0   = 1'b0;
    word_we1   = 1'b0;
    lru_we     = 1'b0;
    lru_val    = 1'b0;
    cpu_rdata  = '0;
    cpu_stall  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        if (cpu_wr) begin
          capture_wr = 1'b1;
          cpu_stall  = 1'b1;
          state_d    = WRITE;
        end else if (cpu_rd) begin
          if (hit) begin
            cpu_rdata = hit_w0 ? rdata_w0 : rdata_w1;
            lru_we    = 1'b1;
            lru_val   = hit_w0;
          end else begin
            capture_rd = 1'b1;
            cpu_stall  = 1'b1;
            state_d    = REFILL;
          end
        end
      end
      REFILL: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {req_word_q[WADDR_W-1:OFFSET_W], beat_q, 2'b00};
        if (mem_ack) begin
          beat_inc = 1'b1;
          if (beat_q == LAST_BEAT) begin
            line_we0 = ~victim;
            line_we1 = victim;
            lru_we   = 1'b1;
            lru_val  = ~victim;
            state_d  = IDLE;
          end
        end
      end
      WRITE: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {req_word_q, 2'b00};
        mem_wdata = req_wdata_q;
        if (mem_ack) begin
          word_we0 = hit_w0;
          word_we1 = hit_w1;
          lru_we   = hit;
          lru_val  = hit_w0;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_word_q  <= '0;
      req_wdata_q <= '0;
      beat_q      <= '0;
    end else begin
      if (capture_wr) begin
        req_word_q  <= cpu_addr[ADDR_W-1:2];
        req_wdata_q <= cpu_wdata;
      end
      if (capture_rd) begin
        req_word_q <= {cpu_addr[ADDR_W-1:OFFSET_W+2], {OFFSET_W{1'b0}}};
        beat_q     <= '0;
      end
      if (beat_inc) beat_q <= beat_q + OFFSET_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (beat_inc) line_buf_q[beat_q] <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush)  lru_q <= '0;
    else if (lru_we)   lru_q[lk_index] <= lru_val;
  end

endmodule

`default_nettype wire

// File: tb/tb_set_assoc_cache.sv
// ============================================================================
// Module   : tb_set_assoc_cache
// Purpose  : Directed self-checking bench for set_assoc_cache with a latency-2 memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_set_assoc_cache;

  localparam int ADDR_W   = 18;
  localparam int DATA_W   = 32;
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 1;
  localparam int LAT      = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_rd = 1'b0;
  logic              cpu_wr = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              flush = 1'b0;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  set_assoc_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Memory: ack arrives LAT cycles into each request; unwritten words have a fixed pattern.
  logic [DATA_W-1:0] mem_store [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] rd_log[$];
  logic [ADDR_W-1:0] wr_log[$];
  int rd_beats = 0, wr_beats = 0, req_cycles = 0, wait_cnt = 0;

  function automatic logic [DATA_W-1:0] mem_value(input logic [ADDR_W-1:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    if (a == 18'h00100) return 32'h11111111;
    if (a == 18'h00104) return 32'h22222222;
    return 32'hC0DE0000 ^ {14'd0, a};
  endfunction

  always @(posedge clk) begin
    if (mem_req) req_cycles++;
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        wr_beats++;
        wr_log.push_back(mem_addr);
        mem_store[mem_addr] = mem_wdata;
      end else begin
        rd_beats++;
        rd_log.push_back(mem_addr);
      end
    end
    if (!mem_req || mem_ack) begin
      mem_ack <= 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= LAT - 2) begin
      mem_ack   <= 1'b1;
      mem_rdata <= mem_value(mem_addr);
    end else begin
      wait_cnt++;
    end
  end

  task automatic do_read(input logic [ADDR_W-1:0] addr, input bit flush_last,
                         output int stall, output logic [DATA_W-1:0] data);
    bit flushed;
    flushed = 1'b0;
    stall = 0;
    data = '0;
    cpu_rd = 1'b1;
    cpu_addr = addr;
    forever begin
      @(negedge clk);
      if (flush_last && !flushed && mem_req && mem_ack && !mem_we && mem_addr == (addr | 18'h4)) begin
        flush = 1'b1;
        flushed = 1'b1;
      end
      if (!cpu_stall) begin
        data = cpu_rdata;
        break;
      end
      stall++;
      if (stall > 40) begin
        tests++; fails++;
        $display("FAIL read_timeout addr=%h stalled %0d cycles, required completion within 40", addr, stall);
        break;
      end
      @(posedge clk); #1;
      flush = 1'b0;
    end
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                          output int stall);
    stall = 0;
    cpu_wr = 1'b1;
    cpu_addr = addr;
    cpu_wdata = wdata;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      stall++;
      if (stall > 40) begin
        tests++; fails++;
        $display("FAIL write_timeout addr=%h stalled %0d cycles, required completion within 40", addr, stall);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cpu_wr = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
    tests++; if (cpu_rdata !== '0)   begin fails++; $display("FAIL reset_rdata got %h want 0", cpu_rdata); end
    tests++; if (mem_req !== 1'b0)   begin fails++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    tests++; if (mem_we !== 1'b0)    begin fails++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    tests++; if (mem_addr !== '0)    begin fails++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    tests++; if (mem_wdata !== '0)   begin fails++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_cold_read();
    int stall, rb0, rq0, li;
    logic [DATA_W-1:0] data;
    rb0 = rd_beats; li = rd_log.size();
    do_read(18'h00100, 1'b0, stall, data);
    tests++; if (stall != 5) begin fails++; $display("FAIL cold_stall got %0d want 5", stall); end
    tests++; if (rd_beats - rb0 != 2) begin fails++; $display("FAIL cold_beats got %0d want 2", rd_beats - rb0); end
    tests++; if (rd_log.size() < li + 2 || rd_log[li] !== 18'h00100) begin fails++; $display("FAIL cold_beat0_addr got %h want 00100", (rd_log.size() > li) ? rd_log[li] : 18'h3ffff); end
    tests++; if (rd_log.size() < li + 2 || rd_log[li+1] !== 18'h00104) begin fails++; $display("FAIL cold_beat1_addr got %h want 00104", (rd_log.size() > li + 1) ? rd_log[li+1] : 18'h3ffff); end
    tests++; if (data !== 32'h11111111) begin fails++; $display("FAIL cold_data got %h want 11111111", data); end
    rq0 = req_cycles;
    do_read(18'h00104, 1'b0, stall, data);
    tests++; if (stall != 0) begin fails++; $display("FAIL hit104_stall got %0d want 0", stall); end
    tests++; if (data !== 32'h22222222) begin fails++; $display("FAIL hit104_data got %h want 22222222", data); end
    tests++; if (req_cycles != rq0) begin fails++; $display("FAIL hit104_mem_req got %0d req cycles want 0", req_cycles - rq0); end
  endtask

  task automatic test_write_hit();
    int stall, wb0, rb0, rq0, li;
    logic [DATA_W-1:0] data;
    wb0 = wr_beats; rb0 = rd_beats; li = wr_log.size();
    do_write(18'h00104, 32'hDEADBEEF, stall);
    tests++; if (stall != 3) begin fails++; $display("FAIL wrhit_stall got %0d want 3", stall); end
    tests++; if (wr_beats - wb0 != 1) begin fails++; $display("FAIL wrhit_wbeats got %0d want 1", wr_beats - wb0); end
    tests++; if (wr_log.size() <= li || wr_log[li] !== 18'h00104) begin fails++; $display("FAIL wrhit_addr got %h want 00104", (wr_log.size() > li) ? wr_log[li] : 18'h3ffff); end
    tests++; if (rd_beats != rb0) begin fails++; $display("FAIL wrhit_rbeats got %0d want 0", rd_beats - rb0); end
    rq0 = req_cycles;
    do_read(18'h00104, 1'b0, stall, data);
    tests++; if (data !== 32'hDEADBEEF) begin fails++; $display("FAIL wrhit_readback got %h want deadbeef", data); end
    tests++; if (stall != 0 || req_cycles != rq0) begin fails++; $display("FAIL wrhit_readback_stall got stall %0d req %0d want 0 0", stall, req_cycles - rq0); end
  endtask

  task automatic test_write_miss();
    int stall, wb0, rb0;
    logic [DATA_W-1:0] data;
    wb0 = wr_beats; rb0 = rd_beats;
    do_write(18'h08100, 32'hCAFEF00D, stall);
    tests++; if (stall != 3) begin fails++; $display("FAIL wrmiss_stall got %0d want 3", stall); end
    tests++; if (wr_beats - wb0 != 1 || rd_beats != rb0) begin fails++; $display("FAIL wrmiss_beats got w%0d r%0d want w1 r0", wr_beats - wb0, rd_beats - rb0); end
    rb0 = rd_beats;
    do_read(18'h08100, 1'b0, stall, data);
    tests++; if (rd_beats - rb0 != 2) begin fails++; $display("FAIL wrmiss_no_alloc got %0d refill beats want 2", rd_beats - rb0); end
    tests++; if (stall != 5) begin fails++; $display("FAIL wrmiss_read_stall got %0d want 5", stall); end
    tests++; if (data !== 32'hCAFEF00D) begin fails++; $display("FAIL wrmiss_read_data got %h want cafef00d", data); end
  endtask

  task automatic test_lru();
    int stall;
    logic [DATA_W-1:0] data;
    pulse_flush();
    do_read(18'h00100, 1'b0, stall, data);
    tests++; if (stall != 5 || data !== 32'h11111111) begin fails++; $display("FAIL lru_a_miss got stall %0d data %h want 5 11111111", stall, data); end
    do_read(18'h00300, 1'b0, stall, data);
    tests++; if (stall != 5 || data !== 32'hC0DE0300) begin fails++; $display("FAIL lru_b_miss got stall %0d data %h want 5 c0de0300", stall, data); end
    do_read(18'h00100, 1'b0, stall, data);
    tests++; if (stall != 0 || data !== 32'h11111111) begin fails++; $display("FAIL lru_a_hit got stall %0d data %h want 0 11111111", stall, data); end
    do_read(18'h00500, 1'b0, stall, data);
    tests++; if (stall != 5 || data !== 32'hC0DE0500) begin fails++; $display("FAIL lru_c_miss got stall %0d data %h want 5 c0de0500", stall, data); end
    do_read(18'h00100, 1'b0, stall, data);
    tests++; if (stall != 0) begin fails++; $display("FAIL lru_a_kept got stall %0d want 0", stall); end
    do_read(18'h00300, 1'b0, stall, data);
    tests++; if (stall != 5) begin fails++; $display("FAIL lru_b_evicted got stall %0d want 5", stall); end
  endtask

  task automatic test_flush();
    int stall, rb0;
    logic [DATA_W-1:0] data;
    pulse_flush();
    do_read(18'h00100, 1'b0, stall, data);
    tests++; if (stall != 5) begin fails++; $display("FAIL flush_a_miss got stall %0d want 5", stall); end
    do_read(18'h00300, 1'b0, stall, data);
    tests++; if (stall != 5) begin fails++; $display("FAIL flush_b_miss got stall %0d want 5", stall); end
    pulse_flush();
    rb0 = rd_beats;
    do_read(18'h00100, 1'b1, stall, data);
    tests++; if (stall != 10) begin fails++; $display("FAIL flush_install_stall got %0d want 10", stall); end
    tests++; if (rd_beats - rb0 != 4) begin fails++; $display("FAIL flush_install_beats got %0d want 4", rd_beats - rb0); end
    tests++; if (data !== 32'h11111111) begin fails++; $display("FAIL flush_install_data got %h want 11111111", data); end
    do_read(18'h00100, 1'b0, stall, data);
    tests++; if (stall != 0) begin fails++; $display("FAIL flush_refilled_hit got stall %0d want 0", stall); end
  endtask

  task automatic test_reset_mid_refill();
    int stall, rb0;
    logic [DATA_W-1:0] data;
    cpu_rd = 1'b1;
    cpu_addr = 18'h00500;
    @(negedge clk);
    tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL rstmid_miss_stall got %b want 1", cpu_stall); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rstmid_in_refill got mem_req %b want 1", mem_req); end
    @(posedge clk); #1;
    rst = 1'b1;
    cpu_rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++; if (mem_req !== 1'b0 || mem_addr !== '0) begin fails++; $display("FAIL rstmid_mem got req %b addr %h want 0 0", mem_req, mem_addr); end
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL rstmid_stall got %b want 0", cpu_stall); end
    @(posedge clk); #1;
    rb0 = rd_beats;
    do_read(18'h00100, 1'b0, stall, data);
    tests++; if (stall != 5 || rd_beats - rb0 != 2) begin fails++; $display("FAIL rstmid_remiss got stall %0d beats %0d want 5 2", stall, rd_beats - rb0); end
    tests++; if (data !== 32'h11111111) begin fails++; $display("FAIL rstmid_data got %h want 11111111", data); end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit();
    test_write_miss();
    test_lru();
    test_flush();
    test_reset_mid_refill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
